// File: rtl/id_ex_pipeline_register_pkg.sv
// rtl/id_ex_pipeline_register_pkg.sv - control-bit layout and ALU-operation encodings for the ID/EX register
package id_ex_pipeline_register_pkg;

  localparam int CONTROL_WIDTH  = 9;
  localparam int CTRL_REG_WRITE = 8;
  localparam int CTRL_MEM_TO_REG = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_ALU_SRC   = 3;
  localparam int CTRL_REG_DST   = 2;
  localparam int CTRL_ALU_OP    = 0;

  localparam logic [CONTROL_WIDTH-1:0] NOP_CONTROL = '0;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10,
    ALU_OP_ADD2  = 2'b11
  } alu_operation_t;

endpackage

// File: rtl/id_ex_pipeline_register_field.sv
// rtl/id_ex_pipeline_register_field.sv - pipeline_field_register: one field group with load and clear
module pipeline_field_register #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // clear beats load so flush can override a concurrent hold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// rtl/id_ex_pipeline_register.sv - ID/EX pipeline register with hold, bubble and flush
// Optional ID_EX_PERF_COUNTERS_EN adds saturating bubble_count / flush_count outputs.
module id_ex_pipeline_register
  import id_ex_pipeline_register_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      hold,
  input  logic                      bubble,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [CONTROL_WIDTH-1:0]  id_control,
  input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
  input  logic [DATA_WIDTH-1:0]     id_read_data_1,
  input  logic [DATA_WIDTH-1:0]     id_read_data_2,
  input  logic [DATA_WIDTH-1:0]     id_sign_ext_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  output logic                      ex_valid,
  output logic [CONTROL_WIDTH-1:0]  ex_control,
  output logic [1:0]                ex_alu_operation,
  output logic [5:0]                ex_function_code,
  output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
  output logic [DATA_WIDTH-1:0]     ex_read_data_1,
  output logic [DATA_WIDTH-1:0]     ex_read_data_2,
  output logic [DATA_WIDTH-1:0]     ex_sign_ext_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd
`ifdef ID_EX_PERF_COUNTERS_EN
  ,
  output logic [31:0]               bubble_count,
  output logic [31:0]               flush_count
`endif
);

  localparam int DATA_GROUP  = 4 * DATA_WIDTH;
  localparam int INDEX_GROUP = 3 * REG_ADDR_WIDTH;

  logic advance;
  logic bubble_win;
  logic valid_clear;
  logic control_clear;

  assign advance       = !hold;
  assign bubble_win    = !flush && !hold && bubble;
  assign valid_clear   = flush || bubble_win;
  // an invalid ID slot must never carry control bits into EX
  assign control_clear = valid_clear || (!flush && !hold && !id_valid);

  pipeline_field_register #(.WIDTH(1)) u_valid (
    .clock(clock), .reset_n(reset_n), .load(advance), .clear(valid_clear),
    .d(id_valid), .q(ex_valid)
  );

  pipeline_field_register #(.WIDTH(CONTROL_WIDTH)) u_control (
    .clock(clock), .reset_n(reset_n), .load(advance), .clear(control_clear),
    .d(id_control), .q(ex_control)
  );

  pipeline_field_register #(.WIDTH(DATA_GROUP)) u_data (
    .clock(clock), .reset_n(reset_n), .load(advance), .clear(flush),
    .d({id_pc_plus4, id_read_data_1, id_read_data_2, id_sign_ext_imm}),
    .q({ex_pc_plus4, ex_read_data_1, ex_read_data_2, ex_sign_ext_imm})
  );

  pipeline_field_register #(.WIDTH(INDEX_GROUP)) u_index (
    .clock(clock), .reset_n(reset_n), .load(advance), .clear(flush),
    .d({id_rs, id_rt, id_rd}),
    .q({ex_rs, ex_rt, ex_rd})
  );

  assign ex_alu_operation = ex_control[CTRL_ALU_OP +: 2];
  assign ex_function_code = ex_sign_ext_imm[5:0];

`ifdef ID_EX_PERF_COUNTERS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (bubble_win && (bubble_count != '1)) bubble_count <= bubble_count + 32'd1;
      if (flush && (flush_count != '1))       flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb/tb_id_ex_pipeline_register.sv - directed plus randomized checks against a behavioural ID/EX model
module tb_id_ex_pipeline_register;

  logic        clock = 1'b0;
  logic        reset_n, hold, bubble, flush, id_valid;
  logic [8:0]  id_control;
  logic [31:0] id_pc_plus4, id_read_data_1, id_read_data_2, id_sign_ext_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_valid;
  logic [8:0]  ex_control;
  logic [1:0]  ex_alu_operation;
  logic [5:0]  ex_function_code;
  logic [31:0] ex_pc_plus4, ex_read_data_1, ex_read_data_2, ex_sign_ext_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
`ifdef ID_EX_PERF_COUNTERS_EN
  logic [31:0] bubble_count, flush_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  // expected EX-stage state
  logic        m_valid;
  logic [8:0]  m_ctrl;
  logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_bc, m_fc;

  id_ex_pipeline_register dut (
    .clock(clock), .reset_n(reset_n), .hold(hold), .bubble(bubble), .flush(flush),
    .id_valid(id_valid), .id_control(id_control), .id_pc_plus4(id_pc_plus4),
    .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
    .id_sign_ext_imm(id_sign_ext_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_control(ex_control), .ex_alu_operation(ex_alu_operation),
    .ex_function_code(ex_function_code), .ex_pc_plus4(ex_pc_plus4),
    .ex_read_data_1(ex_read_data_1), .ex_read_data_2(ex_read_data_2),
    .ex_sign_ext_imm(ex_sign_ext_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
`ifdef ID_EX_PERF_COUNTERS_EN
    , .bubble_count(bubble_count), .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0;
    m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0;
    m_bc = '0; m_fc = '0;
  endtask

  // one rising edge, decided by priority flush > hold > bubble > load
  task automatic model_edge();
    if (flush) begin
      m_valid = 1'b0; m_ctrl = '0;
      m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    end else if (!hold) begin
      m_pc = id_pc_plus4; m_rd1 = id_read_data_1; m_rd2 = id_read_data_2; m_imm = id_sign_ext_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      if (bubble) begin
        m_valid = 1'b0; m_ctrl = '0;
        if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      end else begin
        m_valid = id_valid;
        m_ctrl  = id_valid ? id_control : 9'd0;
      end
    end
  endtask

  task automatic check_all();
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    check("ex_control", {23'd0, ex_control}, {23'd0, m_ctrl});
    check("ex_alu_operation", {30'd0, ex_alu_operation}, {30'd0, m_ctrl[1:0]});
    check("ex_function_code", {26'd0, ex_function_code}, {26'd0, m_imm[5:0]});
    check("ex_pc_plus4", ex_pc_plus4, m_pc);
    check("ex_read_data_1", ex_read_data_1, m_rd1);
    check("ex_read_data_2", ex_read_data_2, m_rd2);
    check("ex_sign_ext_imm", ex_sign_ext_imm, m_imm);
    check("ex_regs", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, m_rs, m_rt, m_rd});
    check("valid_implies_control", {31'd0, (!ex_valid && ex_control != 0)}, 32'd0);
`ifdef ID_EX_PERF_COUNTERS_EN
    check("bubble_count", bubble_count, m_bc);
    check("flush_count", flush_count, m_fc);
`endif
  endtask

  task automatic rand_id();
    id_valid        = 1'($urandom_range(0, 3) != 0);
    id_control      = 9'($urandom);
    id_pc_plus4     = $urandom;
    id_read_data_1  = $urandom;
    id_read_data_2  = $urandom;
    id_sign_ext_imm = $urandom;
    id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic async_reset_pulse();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; hold = 1'b0; bubble = 1'b0; flush = 1'b0;
    rand_id();
    @(posedge clock);
    #1;
    model_reset();
    check_all();
    reset_n = 1'b1;

    // R-type in EX, then asynchronous reset between edges
    rand_id();
    id_valid = 1'b1; id_control = 9'b1_0_0_0_0_0_1_10; id_sign_ext_imm = 32'h0000_0022;
    tick();
    check("rtype_alu_op", {30'd0, ex_alu_operation}, 32'd2);
    async_reset_pulse();

    // normal load
    rand_id();
    id_valid = 1'b1; id_control = 9'b1_0_0_0_0_0_1_10;
    id_sign_ext_imm = 32'h0000_002A; id_read_data_1 = 32'h0000_1234;
    tick();
    check("load_funct", {26'd0, ex_function_code}, 32'h2A);
    check("load_alu_op", {30'd0, ex_alu_operation}, 32'd2);
    check("load_rd1", ex_read_data_1, 32'h1234);
    check("load_valid", {31'd0, ex_valid}, 32'd1);

    // hold for three cycles while ID churns
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      bubble = 1'($urandom);
      tick();
      check("hold_funct", {26'd0, ex_function_code}, 32'h2A);
    end
    hold = 1'b0; bubble = 1'b0;
    rand_id();
    tick();

    // lw in EX, one bubble, then the dependent instruction
    rand_id();
    id_valid = 1'b1; id_control = 9'b1_1_1_0_0_1_0_00;
    tick();
    bubble = 1'b1;
    rand_id();
    id_valid = 1'b1; id_control = 9'b1_0_0_0_0_0_1_10;
    tick();
    check("bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("bubble_control", {23'd0, ex_control}, 32'd0);
    bubble = 1'b0;
    tick();
    check("dependent_valid", {31'd0, ex_valid}, 32'd1);

    // flush and hold on the same edge
    flush = 1'b1; hold = 1'b1;
    rand_id();
    tick();
    check("flush_hold_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_hold_control", {23'd0, ex_control}, 32'd0);
    flush = 1'b0; hold = 1'b0;

    // counter scenario from a clean reset
    async_reset_pulse();
    bubble = 1'b1; rand_id(); tick();
    rand_id(); tick();
    bubble = 1'b0; flush = 1'b1; rand_id(); tick();
    flush = 1'b0; hold = 1'b1; bubble = 1'b1; rand_id(); tick();
    hold = 1'b0; bubble = 1'b0; rand_id(); tick();
`ifdef ID_EX_PERF_COUNTERS_EN
    check("bubble_count_scenario", bubble_count, 32'd2);
    check("flush_count_scenario", flush_count, 32'd1);
`endif

    // randomized control mix, with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      rand_id();
      hold   = 1'($urandom_range(0, 3) == 0);
      bubble = 1'($urandom_range(0, 3) == 0);
      flush  = 1'($urandom_range(0, 5) == 0);
      tick();
      if ($urandom_range(0, 39) == 0) async_reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
